// File: rtl/npu_input_pool2x2.sv
// npu_input_pool2x2: 2x2 round-half-up average pool of the planar RGB image into activation memory (start/halt/rows_avail in; busy/done/halted/cur_row status; rgb_addr/rgb_rddata read port; act_we/act_addr/act_wrdata write port)
module npu_input_pool2x2 #(
  parameter int IN_W = 32,
  parameter int IN_H = 32,
  parameter int NUM_CH = 3,
  parameter logic [11:0] OUT_BASE = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [5:0]  rows_avail,
  output logic        busy,
  output logic        done,
  output logic        halted,
  output logic [4:0]  cur_row,
  output logic [11:0] rgb_addr,
  input  logic [7:0]  rgb_rddata,
  output logic        act_we,
  output logic [11:0] act_addr,
  output logic [7:0]  act_wrdata
);
  localparam int XW = $clog2(IN_W / 2);
  localparam int RW = $clog2(IN_H / 2);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [11:0] PLANE = 12'(IN_W * IN_H);
  localparam logic [11:0] ROW = 12'(IN_W);
  localparam logic [11:0] OPLANE = 12'(IN_W * IN_H / 4);
  localparam logic [11:0] OROW = 12'(IN_W / 2);
  typedef enum logic [3:0] {IDLE, WAIT_ROWS, RD0, RD1, RD2, RD3, WR, HALT, DONE} state_t;
  state_t state, state_n;
  logic [XW-1:0] x;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [9:0] sum;
  logic [11:0] addr_q, rd_addr;
  logic last_x, last_c, last_r, row_end, last, row_start, rows_ok, rd, dy, dx;
  always_comb begin
    last_x = x == XW'(IN_W / 2 - 1);
    last_c = c == CW'(NUM_CH - 1);
    last_r = r == RW'(IN_H / 2 - 1);
    row_end = last_x && last_c;
    last = row_end && last_r;
    row_start = x == '0 && c == '0;
    rows_ok = {1'b0, rows_avail} >= 7'({r, 1'b0}) + 7'd2;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? WAIT_ROWS : IDLE;
      WAIT_ROWS: state_n = rows_ok ? RD0 : WAIT_ROWS;
      RD0:       state_n = RD1;
      RD1:       state_n = RD2;
      RD2:       state_n = RD3;
      RD3:       state_n = WR;
      WR:        state_n = last ? DONE : halt ? HALT : row_end ? WAIT_ROWS : RD0;
      HALT:      state_n = halt ? HALT : row_start ? WAIT_ROWS : RD0;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    rd = state inside {RD0, RD1, RD2, RD3};
    dy = state inside {RD2, RD3};
    dx = state inside {RD1, RD3};
    rd_addr = 12'(c) * PLANE + 12'({r, dy}) * ROW + 12'({x, dx});
    rgb_addr = rd ? rd_addr : addr_q;
    busy = !(state inside {IDLE, DONE});
    done = state == DONE;
    halted = state == HALT;
    cur_row = 5'(r);
    act_we = state == WR;
    act_addr = act_we ? OUT_BASE + 12'(c) * OPLANE + 12'(r) * OROW + 12'(x) : '0;
    act_wrdata = act_we ? 8'((sum + 10'(rgb_rddata) + 10'd2) >> 2) : '0;
  end
  // counters step on WR so that HALT and DONE already see the next pixel (and DONE sees row 0)
  always_ff @(posedge clk)
    if (reset) begin
      x <= '0;
      c <= '0;
      r <= '0;
      sum <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= rgb_addr;
      if (state == RD1) sum <= 10'(rgb_rddata);
      else if (state == RD2 || state == RD3) sum <= sum + 10'(rgb_rddata);
      if (state == WR) begin
        x <= last_x ? '0 : x + 1'b1;
        if (last_x) c <= last_c ? '0 : c + 1'b1;
        if (row_end) r <= last_r ? '0 : r + 1'b1;
      end
    end
endmodule

// File: tb/tb_npu_input_pool2x2.sv
// tb_npu_input_pool2x2: randomized self-checking bench for npu_input_pool2x2 against an arithmetic pooling model
module tb_npu_input_pool2x2;
  logic clk = 0, reset, start, halt;
  logic [5:0] rows_avail;
  logic busy, done, halted, act_we;
  logic [4:0] cur_row;
  logic [11:0] rgb_addr, act_addr;
  logic [7:0] rgb_rddata, act_wrdata;
  logic [7:0] mem [0:4095];
  int errors = 0, checks = 0;
  int wa[$], wd[$];
  npu_input_pool2x2 dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .rows_avail(rows_avail),
    .busy(busy), .done(done), .halted(halted), .cur_row(cur_row),
    .rgb_addr(rgb_addr), .rgb_rddata(rgb_rddata),
    .act_we(act_we), .act_addr(act_addr), .act_wrdata(act_wrdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rgb_rddata <= mem[rgb_addr];
  always @(negedge clk)
    if (act_we) begin
      wa.push_back(int'(act_addr));
      wd.push_back(int'(act_wrdata));
    end
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int pool(int c, int r, int x);
    int a = c * 1024 + 2 * r * 32 + 2 * x;
    return (int'(mem[a]) + int'(mem[a + 1]) + int'(mem[a + 32]) + int'(mem[a + 33]) + 2) / 4;
  endfunction
  task automatic set_px(int x, int t0, int t1, int t2, int t3);
    mem[2 * x] = 8'(t0);
    mem[2 * x + 1] = 8'(t1);
    mem[2 * x + 32] = 8'(t2);
    mem[2 * x + 33] = 8'(t3);
  endtask
  task automatic fill();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    set_px(0, 10, 11, 12, 13);
    set_px(1, 1, 1, 1, 0);
    set_px(2, 1, 1, 0, 0);
    set_px(3, 1, 0, 0, 0);
    set_px(4, 255, 255, 255, 255);
  endtask
  task automatic check_pass(string tag);
    int i = 0;
    chk({tag, "_count"}, wa.size(), 768);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 3; c++)
        for (int x = 0; x < 16; x++) begin
          chk({tag, "_addr"}, i < wa.size() ? wa[i] : -1, c * 256 + r * 16 + x);
          chk({tag, "_data"}, i < wd.size() ? wd[i] : -1, pool(c, r, x));
          i++;
        end
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic run_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", int'(done), 1);
  endtask
  task automatic wait_writes(int n);
    int k = 0, t = 0;
    while (k < n && t < 20000) begin
      @(negedge clk);
      t++;
      if (act_we) k++;
    end
    chk("write_wait", k, n);
  endtask
  initial begin
    int cyc, a0, n;
    reset = 1; start = 0; halt = 0; rows_avail = 0;
    fill();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_cur_row", int'(cur_row), 0);
    chk("rst_rgb_addr", int'(rgb_addr), 0);
    chk("rst_act_we", int'(act_we), 0);
    chk("rst_act_addr", int'(act_addr), 0);
    chk("rst_act_wrdata", int'(act_wrdata), 0);
    reset = 0;
    // full pass with rounding corner pixels at the start of plane 0
    rows_avail = 32;
    wa.delete(); wd.delete();
    pulse_start();
    chk("busy_rise", int'(busy), 1);
    run_done(cyc);
    chk("pass_cycles", cyc, 3856);
    chk("px0_addr", wa.size() > 0 ? wa[0] : -1, 0);
    chk("px0_taps_10_13", wd.size() > 0 ? wd[0] : -1, 12);
    chk("round_1110", wd.size() > 1 ? wd[1] : -1, 1);
    chk("round_1100", wd.size() > 2 ? wd[2] : -1, 1);
    chk("round_1000", wd.size() > 3 ? wd[3] : -1, 0);
    chk("sat_255", wd.size() > 4 ? wd[4] : -1, 255);
    check_pass("ramp");
    start = 1;
    @(negedge clk) start = 0;
    chk("done_pulse", int'(done), 0);
    repeat (10) @(negedge clk);
    chk("start_in_done_busy", int'(busy), 0);
    chk("start_in_done_writes", wa.size(), 768);
    // row gating, plus a start pulse while busy
    fill();
    wa.delete(); wd.delete();
    rows_avail = 1;
    a0 = int'(rgb_addr);
    pulse_start();
    repeat (50) @(negedge clk);
    chk("gate_writes", wa.size(), 0);
    chk("gate_rgb_idle", int'(rgb_addr), a0);
    chk("gate_busy", int'(busy), 1);
    chk("gate_cur_row", int'(cur_row), 0);
    pulse_start();
    rows_avail = 2;
    wait_writes(48);
    repeat (50) @(negedge clk);
    chk("gate_row0_writes", wa.size(), 48);
    chk("gate_cur_row1", int'(cur_row), 1);
    chk("gate_busy_stall", int'(busy), 1);
    rows_avail = 32;
    run_done(cyc);
    check_pass("gate");
    // halt raised in RD2 of the 11th pixel
    fill();
    wa.delete(); wd.delete();
    pulse_start();
    wait_writes(10);
    repeat (3) @(negedge clk);
    halt = 1;
    @(negedge clk);
    @(negedge clk);
    chk("halt_wr_completes", int'(act_we), 1);
    chk("halt_not_yet", int'(halted), 0);
    @(negedge clk);
    chk("halted_next", int'(halted), 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (act_we) n++;
    end
    chk("halt_no_writes", n, 0);
    chk("halt_held", int'(halted), 1);
    chk("halt_count", wa.size(), 11);
    halt = 0;
    run_done(cyc);
    check_pass("halt");
    // reset mid-pass, then a fresh full pass
    wa.delete(); wd.delete();
    pulse_start();
    wait_writes(100);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_act_we", int'(act_we), 0);
    chk("mid_rst_halted", int'(halted), 0);
    chk("mid_rst_cur_row", int'(cur_row), 0);
    @(negedge clk) reset = 0;
    repeat (5) @(negedge clk);
    chk("mid_rst_idle", int'(busy), 0);
    fill();
    wa.delete(); wd.delete();
    pulse_start();
    run_done(cyc);
    chk("rst_pass_cycles", cyc, 3856);
    check_pass("after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
